// File: rtl/jtag_tx_fifo.sv
// jtag_tx_fifo: return-path FIFO for the virtual-JTAG link, tck domain only.
// Design logic enqueues 32-bit words; the host drains them with POP DR scans
// (IR 3'b010) and reads fill level / error flags with STATUS scans (IR 3'b011).
// Ports:
//   tck, reset_n           clock, async active-low reset
//   tdi, ir_in, cdr/sdr/udr virtual-JTAG data in, IR and DR state strobes
//   tdo_tx, tdo_en         serial data out (LSB of shift register), select
//   in_data/in_valid/in_ready  enqueue handshake
//   count, overflow        occupancy and sticky write-while-full flag
`timescale 1ns/1ps
module jtag_tx_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic          tck,
  input  logic          reset_n,
  input  logic          tdi,
  input  logic [2:0]    ir_in,
  input  logic          cdr,
  input  logic          sdr,
  input  logic          udr,
  output logic          tdo_tx,
  output logic          tdo_en,
  input  logic [31:0]   in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [CW-1:0] count,
  output logic          overflow
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam logic [2:0]  IR_POP    = 3'b010;
  localparam logic [2:0]  IR_STATUS = 3'b011;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count_q;
  logic [31:0]   shift_q;
  logic          pop_pend;
  logic          overflow_q;

  logic          is_pop;
  logic          is_status;
  logic          full;
  logic          empty;
  logic          wr_en;
  logic          pop_commit;
  logic [31:0]   status_word;

  // Command decode and FIFO status
  always_comb begin
    is_pop      = (ir_in == IR_POP);
    is_status   = (ir_in == IR_STATUS);
    full        = (count_q == CW'(DEPTH));
    empty       = (count_q == '0);
    wr_en       = in_valid && !full;
    pop_commit  = udr && is_pop && pop_pend;
    status_word = {overflow_q, full, empty, 13'b0, 16'(count_q)};
  end

  // Storage array; contents are don't-care after reset
  always_ff @(posedge tck) begin
    if (wr_en) mem[wptr] <= in_data;
  end

  // Pointers and occupancy; a simultaneous write and pop leave count unchanged
  always_ff @(posedge tck or negedge reset_n) begin
    if (!reset_n) begin
      wptr    <= '0;
      rptr    <= '0;
      count_q <= '0;
    end else begin
      if (wr_en)      wptr <= wptr + AW'(1);
      if (pop_commit) rptr <= rptr + AW'(1);
      case ({wr_en, pop_commit})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // DR shift register: capture head word or status, then shift LSB first
  always_ff @(posedge tck or negedge reset_n) begin
    if (!reset_n) begin
      shift_q <= '0;
    end else if (cdr && is_pop) begin
      shift_q <= empty ? 32'h0000_0000 : mem[rptr];
    end else if (cdr && is_status) begin
      shift_q <= status_word;
    end else if (sdr && (is_pop || is_status)) begin
      shift_q <= {tdi, shift_q[31:1]};
    end
  end

  // A pop is only committed if its capture actually loaded a word
  always_ff @(posedge tck or negedge reset_n) begin
    if (!reset_n) begin
      pop_pend <= 1'b0;
    end else if (cdr) begin
      pop_pend <= is_pop && !empty;
    end else if (pop_commit) begin
      pop_pend <= 1'b0;
    end
  end

  // Sticky overflow; a set in the same cycle as a STATUS capture wins
  always_ff @(posedge tck or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q <= 1'b0;
    end else if (in_valid && full) begin
      overflow_q <= 1'b1;
    end else if (cdr && is_status) begin
      overflow_q <= 1'b0;
    end
  end

  assign tdo_tx   = shift_q[0];
  assign tdo_en   = is_pop || is_status;
  assign in_ready = !full;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_jtag_tx_fifo.sv
// Directed self-checking bench for jtag_tx_fifo (DEPTH=16).
`timescale 1ns/1ps
module tb_jtag_tx_fifo;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = 5;
  localparam logic [2:0]  IR_IDLE   = 3'b000;
  localparam logic [2:0]  IR_POP    = 3'b010;
  localparam logic [2:0]  IR_STATUS = 3'b011;

  logic          tck;
  logic          reset_n;
  logic          tdi;
  logic [2:0]    ir_in;
  logic          cdr;
  logic          sdr;
  logic          udr;
  logic          tdo_tx;
  logic          tdo_en;
  logic [31:0]   in_data;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] count;
  logic          overflow;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  jtag_tx_fifo #(.DEPTH(DEPTH)) dut (
    .tck      (tck),
    .reset_n  (reset_n),
    .tdi      (tdi),
    .ir_in    (ir_in),
    .cdr      (cdr),
    .sdr      (sdr),
    .udr      (udr),
    .tdo_tx   (tdo_tx),
    .tdo_en   (tdo_en),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .count    (count),
    .overflow (overflow)
  );

  initial tck = 1'b0;
  always #5 tck = ~tck;

  // Advance one edge and settle away from it
  task automatic tick();
    @(posedge tck);
    #1;
  endtask

  task automatic push(input logic [31:0] d);
    in_data  = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Full DR scan: capture, 32 shifts sampling tdo_tx, update (optionally with a write)
  task automatic scan(input logic [2:0] ir, input logic wr_at_udr,
                      input logic [31:0] wdata, output logic [31:0] rx);
    ir_in = ir;
    cdr   = 1'b1;
    tick();
    cdr = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rx[i] = tdo_tx;
      tdi   = 1'b0;
      sdr   = 1'b1;
      tick();
    end
    sdr = 1'b0;
    udr = 1'b1;
    if (wr_at_udr) begin
      in_data  = wdata;
      in_valid = 1'b1;
    end
    tick();
    udr      = 1'b0;
    in_valid = 1'b0;
    ir_in    = IR_IDLE;
  endtask

  task automatic test_reset();
    logic [31:0] rx;
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    chk_cnt++; if (count !== 5'd0) $display("FAIL reset_count got %0d want 0", count); else pass_cnt++;
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else pass_cnt++;
    chk_cnt++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %b want 0", overflow); else pass_cnt++;
    chk_cnt++; if (tdo_tx !== 1'b0) $display("FAIL reset_tdo_tx got %b want 0", tdo_tx); else pass_cnt++;
    chk_cnt++; if (tdo_en !== 1'b0) $display("FAIL tdo_en_idle got %b want 0", tdo_en); else pass_cnt++;
    ir_in = IR_POP;
    #1;
    chk_cnt++; if (tdo_en !== 1'b1) $display("FAIL tdo_en_pop got %b want 1", tdo_en); else pass_cnt++;
    ir_in = IR_IDLE;
    scan(IR_STATUS, 1'b0, 32'h0, rx);
    chk_cnt++; if (rx !== 32'h2000_0000) $display("FAIL reset_status got %h want 20000000", rx); else pass_cnt++;
  endtask

  task automatic test_pop_basic();
    logic [31:0] rx;
    push(32'hA5A5_0001);
    push(32'hA5A5_0002);
    chk_cnt++; if (count !== 5'd2) $display("FAIL basic_count2 got %0d want 2", count); else pass_cnt++;
    scan(IR_POP, 1'b0, 32'h0, rx);
    chk_cnt++; if (rx !== 32'hA5A5_0001) $display("FAIL basic_pop1 got %h want a5a50001", rx); else pass_cnt++;
    chk_cnt++; if (count !== 5'd1) $display("FAIL basic_count1 got %0d want 1", count); else pass_cnt++;
    scan(IR_POP, 1'b0, 32'h0, rx);
    chk_cnt++; if (rx !== 32'hA5A5_0002) $display("FAIL basic_pop2 got %h want a5a50002", rx); else pass_cnt++;
    chk_cnt++; if (count !== 5'd0) $display("FAIL basic_count0 got %0d want 0", count); else pass_cnt++;
  endtask

  task automatic test_empty_pop();
    logic [31:0] rx;
    scan(IR_POP, 1'b0, 32'h0, rx);
    chk_cnt++; if (rx !== 32'h0) $display("FAIL empty_pop_data got %h want 00000000", rx); else pass_cnt++;
    chk_cnt++; if (count !== 5'd0) $display("FAIL empty_pop_count got %0d want 0", count); else pass_cnt++;
    push(32'hDEAD_BEEF);
    scan(IR_POP, 1'b0, 32'h0, rx);
    chk_cnt++; if (rx !== 32'hDEAD_BEEF) $display("FAIL empty_then_write got %h want deadbeef", rx); else pass_cnt++;
    chk_cnt++; if (count !== 5'd0) $display("FAIL empty_then_write_count got %0d want 0", count); else pass_cnt++;
  endtask

  task automatic test_full_overflow();
    logic [31:0] rx;
    for (int i = 0; i < DEPTH; i++) push(32'h1000_0000 + 32'(i));
    chk_cnt++; if (count !== 5'd16) $display("FAIL full_count got %0d want 16", count); else pass_cnt++;
    chk_cnt++; if (in_ready !== 1'b0) $display("FAIL full_in_ready got %b want 0", in_ready); else pass_cnt++;
    chk_cnt++; if (overflow !== 1'b0) $display("FAIL full_no_ovf_yet got %b want 0", overflow); else pass_cnt++;
    push(32'hBAD0_BAD0);
    chk_cnt++; if (overflow !== 1'b1) $display("FAIL ovf_set got %b want 1", overflow); else pass_cnt++;
    chk_cnt++; if (count !== 5'd16) $display("FAIL ovf_count got %0d want 16", count); else pass_cnt++;
    scan(IR_STATUS, 1'b0, 32'h0, rx);
    chk_cnt++; if (rx !== 32'hC000_0010) $display("FAIL status_ovf got %h want c0000010", rx); else pass_cnt++;
    chk_cnt++; if (overflow !== 1'b0) $display("FAIL ovf_cleared got %b want 0", overflow); else pass_cnt++;
    scan(IR_STATUS, 1'b0, 32'h0, rx);
    chk_cnt++; if (rx !== 32'h4000_0010) $display("FAIL status_full got %h want 40000010", rx); else pass_cnt++;
    for (int i = 0; i < DEPTH; i++) begin
      scan(IR_POP, 1'b0, 32'h0, rx);
      chk_cnt++;
      if (rx !== 32'h1000_0000 + 32'(i)) $display("FAIL drain_%0d got %h want %h", i, rx, 32'h1000_0000 + 32'(i));
      else pass_cnt++;
    end
    chk_cnt++; if (count !== 5'd0) $display("FAIL drain_count got %0d want 0", count); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] rx;
    push(32'h0000_0030);
    push(32'h0000_0031);
    push(32'h0000_0032);
    scan(IR_POP, 1'b1, 32'h0000_0033, rx);
    chk_cnt++; if (rx !== 32'h0000_0030) $display("FAIL simul_pop got %h want 00000030", rx); else pass_cnt++;
    chk_cnt++; if (count !== 5'd3) $display("FAIL simul_count got %0d want 3", count); else pass_cnt++;
    for (int i = 1; i < 4; i++) begin
      scan(IR_POP, 1'b0, 32'h0, rx);
      chk_cnt++;
      if (rx !== 32'h30 + 32'(i)) $display("FAIL simul_drain_%0d got %h want %h", i, rx, 32'h30 + 32'(i));
      else pass_cnt++;
    end
    // Many write/pop pairs so both pointers wrap several times
    for (int i = 0; i < 40; i++) begin
      push(32'hC0DE_0000 + 32'(i));
      scan(IR_POP, 1'b0, 32'h0, rx);
      chk_cnt++;
      if (rx !== 32'hC0DE_0000 + 32'(i)) $display("FAIL wrap_%0d got %h want %h", i, rx, 32'hC0DE_0000 + 32'(i));
      else pass_cnt++;
    end
    chk_cnt++; if (count !== 5'd0) $display("FAIL wrap_count got %0d want 0", count); else pass_cnt++;
  endtask

  task automatic test_reset_mid_scan();
    logic [31:0] rx;
    for (int i = 0; i < 5; i++) push(32'hFFFF_FFF0 + 32'(i));
    chk_cnt++; if (count !== 5'd5) $display("FAIL mid_count5 got %0d want 5", count); else pass_cnt++;
    ir_in = IR_POP;
    cdr   = 1'b1;
    tick();
    cdr = 1'b0;
    tdi = 1'b1;
    sdr = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    reset_n = 1'b0;
    #1;
    chk_cnt++; if (count !== 5'd0) $display("FAIL mid_reset_count got %0d want 0", count); else pass_cnt++;
    chk_cnt++; if (tdo_tx !== 1'b0) $display("FAIL mid_reset_tdo got %b want 0", tdo_tx); else pass_cnt++;
    sdr = 1'b0;
    tdi = 1'b0;
    ir_in = IR_IDLE;
    #1;
    reset_n = 1'b1;
    tick();
    scan(IR_POP, 1'b0, 32'h0, rx);
    chk_cnt++; if (rx !== 32'h0) $display("FAIL post_reset_pop got %h want 00000000", rx); else pass_cnt++;
    chk_cnt++; if (count !== 5'd0) $display("FAIL post_reset_count got %0d want 0", count); else pass_cnt++;
  endtask

  initial begin
    reset_n  = 1'b0;
    tdi      = 1'b0;
    ir_in    = IR_IDLE;
    cdr      = 1'b0;
    sdr      = 1'b0;
    udr      = 1'b0;
    in_data  = 32'h0;
    in_valid = 1'b0;
    test_reset();
    test_pop_basic();
    test_empty_pop();
    test_full_overflow();
    test_back_to_back();
    test_reset_mid_scan();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/jtag_tx_fifo.md
# jtag_tx_fifo

Return-path block for the virtual-JTAG link. Design logic writes 32-bit result words into an internal FIFO, and the host reads them out over JTAG with a POP DR scan (IR 3'b010). A STATUS DR scan (IR 3'b011) reports fill level and error flags. The block sits beside the PUSH receiver, shares the same virtual-JTAG instance and runs entirely in the tck domain; producers in other domains synchronise upstream.

## Interface
Parameters:
- DEPTH, 16: FIFO depth in 32-bit words; power of two, at least 2.
- CW, $clog2(DEPTH)+1: width of the occupancy count.

Ports:
- tck  in  1  sole clock; all state updates on posedge tck.
- reset_n  in  1  asynchronous, active-low reset.
- tdi  in  1  JTAG serial data in.
- ir_in  in  3  virtual IR command: 3'b010 = POP, 3'b011 = STATUS.
- cdr  in  1  virtual_state_cdr (capture-DR).
- sdr  in  1  virtual_state_sdr (shift-DR).
- udr  in  1  virtual_state_udr (update-DR).
- tdo_tx  out  1  serial data out; equals shift_q[0].
- tdo_en  out  1  high when ir_in is POP or STATUS; the top level selects tdo_tx for tdo when this is high.
- in_data  in  32  word to enqueue.
- in_valid  in  1  enqueue request.
- in_ready  out  1  equals !full; a write is accepted when in_valid && in_ready at posedge tck.
- count  out  CW  current occupancy, 0..DEPTH.
- overflow  out  1  sticky flag: set when a write is attempted while full.

## Operation
- Storage: DEPTH x 32 RAM with read and write pointers, each $clog2(DEPTH) bits wide. Pointers wrap modulo DEPTH. Occupancy is held in the count register.
- Write: on an accepted write, mem[wptr] <= in_data, wptr increments and count increments.
- POP capture: on cdr && ir_in==POP:
  - if count != 0: shift_q <= mem[rptr] and pop_pend <= 1;
  - else: shift_q <= 32'h0000_0000 and pop_pend <= 0.
- Shift: on sdr && ir_in is POP or STATUS: shift_q <= {tdi, shift_q[31:1]}. Data is LSB first; 32 shifts deliver the full word.
- POP commit: on udr && ir_in==POP && pop_pend: rptr increments, count decrements and pop_pend clears.
  - pop_pend also clears on any cdr.
  - An empty POP therefore never moves rptr.
- STATUS capture: on cdr && ir_in==STATUS:
  - shift_q <= {overflow, full, empty, 13'b0, count zero-extended to 16};
  - overflow clears in the same cycle. A write attempt while full in that same cycle keeps overflow set, because set wins.
- Simultaneous write and POP commit in one cycle: both take effect and count is unchanged. When full, no write is possible, because in_ready=0.
- Other IR values: shift_q holds, pointers hold, tdo_en=0.
- full = (count==DEPTH); empty = (count==0).

## Timing
- Reset (reset_n=0, asynchronous) sets: pointers 0, count 0, shift_q 0, pop_pend 0, overflow 0. Outputs after reset: tdo_tx=0, in_ready=1, count=0, overflow=0, tdo_en follows ir_in combinationally.
- Reset mid-scan discards FIFO contents and any pending pop. The host's following scan sees an empty FIFO.
- in_ready, tdo_en and tdo_tx are combinational from registers and ir_in; there are no extra pipeline stages.
- A write accepted at edge N is visible to a cdr at edge N+1 or later. A cdr at edge N itself sees the pre-write state.
- A POP committed at udr edge N exposes the next head word to the following cdr.
- count and in_ready reflect writes and pops one edge after the event.
- tdo_tx changes only on tck edges where cdr or sdr is active.

## Test plan
- Reset, then STATUS scan -> 32'h2000_0000 shifted out: empty=1, count=0, overflow=0; in_ready=1.
- Write 32'hA5A5_0001 and 32'hA5A5_0002, then two POP scans (cdr, 32 sdr, udr) -> host receives 32'hA5A5_0001, then 32'hA5A5_0002, LSB first; count goes 2 -> 1 -> 0.
- POP scan on an empty FIFO -> 32'h0000_0000 shifted out; count and rptr unchanged; a following write then POP returns the written word.
- Fill DEPTH=16 words, then assert in_valid once more -> in_ready=0, overflow=1, count=16.
  - A STATUS scan then returns 32'hC000_0010.
  - A second STATUS scan returns 32'h4000_0010 (overflow cleared).
- Write on the same edge as a POP udr with count=3 -> count stays 3; pointer wrap verified by 40 write/pop pairs with incrementing data and no mismatch.
- Assert reset_n=0 during the sdr phase of a POP with count=5 -> count=0 and tdo_tx=0 immediately; after release, POP returns 32'h0 and count stays 0.
